// File: rtl/soc_system_button_pio_irq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : soc_system_button_pio_irq                                 |
// | Brief    : Avalon-MM input PIO with two-flop synchroniser, optional  |
// |            per-bit debounce, rise/fall edge capture and masked irq.  |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module soc_system_button_pio_irq #(
  parameter int              WIDTH           = 4,
  parameter int              DEBOUNCE_CYCLES = 0,
  parameter logic [WIDTH-1:0] FALL_EN_RESET  = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam logic [2:0] c_ADDR_DATA     = 3'd0;
  localparam logic [2:0] c_ADDR_RISE_EN  = 3'd1;
  localparam logic [2:0] c_ADDR_IRQ_MASK = 3'd2;
  localparam logic [2:0] c_ADDR_EDGE_CAP = 3'd3;
  localparam logic [2:0] c_ADDR_FALL_EN  = 3'd4;

  logic [WIDTH-1:0] r_s1;
  logic [WIDTH-1:0] r_s2;
  logic [WIDTH-1:0] r_db;
  logic [WIDTH-1:0] r_db_d;
  logic [WIDTH-1:0] r_rise_en;
  logic [WIDTH-1:0] r_fall_en;
  logic [WIDTH-1:0] r_irq_mask;
  logic [WIDTH-1:0] r_edge_cap;

  logic             w_wr;
  logic [WIDTH-1:0] w_wdata;
  logic [WIDTH-1:0] w_clr;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;
  logic [WIDTH-1:0] w_event;
  logic             w_unused_wdata;

  // Only the low WIDTH bits of the write bus carry register content.
  assign w_wr           = chipselect & ~write_n;
  assign w_wdata        = writedata[WIDTH-1:0];
  assign w_unused_wdata = ^writedata;

  // Two-flop synchroniser for the asynchronous pins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= in_port;
      r_s2 <= r_s1;
    end
  end

  generate
    if (DEBOUNCE_CYCLES <= 1) begin : g_no_filter
      // Without filtering the debounced value simply follows the synchroniser.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_db <= '0;
        end else begin
          r_db <= r_s2;
        end
      end
    end else begin : g_filter
      localparam int              c_CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
      localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);
      localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

      logic [c_CNT_W-1:0] r_cnt [WIDTH];

      // Per-bit stability counter; db only follows s2 after DEBOUNCE_CYCLES
      // consecutive cycles of disagreement, any agreement restarts the count.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_db <= '0;
          for (int i = 0; i < WIDTH; i++) begin
            r_cnt[i] <= '0;
          end
        end else begin
          for (int i = 0; i < WIDTH; i++) begin
            if (r_s2[i] == r_db[i]) begin
              r_cnt[i] <= '0;
            end else if (r_cnt[i] == c_CNT_LAST) begin
              r_db[i]  <= r_s2[i];
              r_cnt[i] <= '0;
            end else begin
              r_cnt[i] <= r_cnt[i] + c_CNT_ONE;
            end
          end
        end
      end
    end
  endgenerate

  // Delayed copy of db for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_db_d <= '0;
    end else begin
      r_db_d <= r_db;
    end
  end

  assign w_rise  = r_db & ~r_db_d;
  assign w_fall  = ~r_db & r_db_d;
  assign w_event = (w_rise & r_rise_en) | (w_fall & r_fall_en);
  assign w_clr   = (w_wr && (address == c_ADDR_EDGE_CAP)) ? w_wdata : '0;

  // Software-writable control registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rise_en  <= '0;
      r_fall_en  <= FALL_EN_RESET;
      r_irq_mask <= '0;
    end else if (w_wr) begin
      if (address == c_ADDR_RISE_EN)  r_rise_en  <= w_wdata;
      if (address == c_ADDR_IRQ_MASK) r_irq_mask <= w_wdata;
      if (address == c_ADDR_FALL_EN)  r_fall_en  <= w_wdata;
    end
  end

  // Edge capture: the set term is OR-ed after the clear so a coincident
  // event is never lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_edge_cap <= '0;
    end else begin
      r_edge_cap <= (r_edge_cap & ~w_clr) | w_event;
    end
  end

  assign irq = |(r_edge_cap & r_irq_mask);

  // Registered read mux, updated every cycle regardless of chipselect.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else begin
      case (address)
        c_ADDR_DATA:     readdata <= 32'(r_db);
        c_ADDR_RISE_EN:  readdata <= 32'(r_rise_en);
        c_ADDR_IRQ_MASK: readdata <= 32'(r_irq_mask);
        c_ADDR_EDGE_CAP: readdata <= 32'(r_edge_cap);
        c_ADDR_FALL_EN:  readdata <= 32'(r_fall_en);
        default:         readdata <= '0;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_soc_system_button_pio_irq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_soc_system_button_pio_irq                              |
// | Brief    : Directed self-checking bench; one instance without and    |
// |            one with an 8-cycle debounce filter.                      |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module tb_soc_system_button_pio_irq;

  logic        clk;
  logic        reset_n;
  logic [2:0]  address;
  logic        cs0;
  logic        cs8;
  logic        write_n;
  logic [31:0] writedata;
  logic [3:0]  in0;
  logic [3:0]  in8;
  logic [31:0] rd0;
  logic [31:0] rd8;
  logic        irq0;
  logic        irq8;

  int n_checks;
  int n_pass;
  logic [31:0] r_val;

  soc_system_button_pio_irq #(.WIDTH(4), .DEBOUNCE_CYCLES(0)) u_dut0 (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (cs0),
    .write_n    (write_n),
    .writedata  (writedata),
    .in_port    (in0),
    .readdata   (rd0),
    .irq        (irq0)
  );

  soc_system_button_pio_irq #(.WIDTH(4), .DEBOUNCE_CYCLES(8)) u_dut8 (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (cs8),
    .write_n    (write_n),
    .writedata  (writedata),
    .in_port    (in8),
    .readdata   (rd8),
    .irq        (irq8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Write strobe is held across exactly one rising edge; returns #1 after it.
  task automatic bus_write(input bit sel8, input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    address   = a;
    writedata = d;
    cs0       = ~sel8;
    cs8       = sel8;
    write_n   = 1'b0;
    @(posedge clk);
    #1;
    cs0     = 1'b0;
    cs8     = 1'b0;
    write_n = 1'b1;
  endtask

  task automatic bus_read(input bit sel8, input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    address = a;
    @(posedge clk);
    #1;
    d = sel8 ? rd8 : rd0;
  endtask

  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    reset_n   = 1'b0;
    address   = 3'd0;
    cs0       = 1'b0;
    cs8       = 1'b0;
    write_n   = 1'b1;
    writedata = 32'h0;
    in0       = 4'h0;
    in8       = 4'h0;

    #12;
    check_value("reset_rd0", rd0, 32'h0);
    check_value("reset_irq0", 32'(irq0), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    bus_read(0, 3'd4, r_val); check_value("fall_en_rst0", r_val, 32'hF);
    bus_read(1, 3'd4, r_val); check_value("fall_en_rst8", r_val, 32'hF);
    bus_read(0, 3'd1, r_val); check_value("rise_en_rst", r_val, 32'h0);
    bus_read(0, 3'd3, r_val); check_value("edge_cap_rst", r_val, 32'h0);

    // Input latency with no filter: db at N+2, readdata at N+3.
    @(negedge clk);
    address = 3'd0;
    in0     = 4'h5;
    wait_edges(3);
    check_value("data_early", rd0, 32'h0);
    wait_edges(1);
    check_value("data_5", rd0, 32'h5);
    bus_read(0, 3'd3, r_val); check_value("no_rise_cap", r_val, 32'h0);
    @(negedge clk);
    in0 = 4'h0;
    wait_edges(5);
    bus_read(0, 3'd3, r_val); check_value("fall_cap_5", r_val, 32'h5);
    check_value("irq_unmasked", 32'(irq0), 32'h0);

    // Rise-only capture on bit1, irq masking and W1C.
    bus_write(0, 3'd3, 32'hF);
    bus_read(0, 3'd3, r_val); check_value("cap_cleared", r_val, 32'h0);
    bus_write(0, 3'd1, 32'h2);
    bus_write(0, 3'd4, 32'h0);
    @(negedge clk);
    in0 = 4'h3;
    wait_edges(10);
    in0 = 4'h0;
    wait_edges(6);
    bus_read(0, 3'd3, r_val); check_value("cap_rise_bit1", r_val, 32'h2);
    check_value("irq_mask0", 32'(irq0), 32'h0);
    bus_write(0, 3'd2, 32'h2);
    check_value("irq_set", 32'(irq0), 32'h1);
    bus_write(0, 3'd3, 32'h2);
    check_value("irq_clr", 32'(irq0), 32'h0);
    bus_read(0, 3'd3, r_val); check_value("cap_clr_bit1", r_val, 32'h0);

    // Clear coincident with a bit3 fall event: set wins.
    bus_write(0, 3'd4, 32'h8);
    @(negedge clk);
    in0 = 4'h8;
    wait_edges(5);
    bus_read(0, 3'd3, r_val); check_value("no_cap_bit3_rise", r_val, 32'h0);
    @(negedge clk);
    in0 = 4'h0;
    repeat (3) @(posedge clk);
    bus_write(0, 3'd3, 32'h8);
    bus_read(0, 3'd3, r_val); check_value("set_wins", r_val, 32'h8);
    bus_write(0, 3'd3, 32'h8);
    bus_read(0, 3'd3, r_val); check_value("plain_clear", r_val, 32'h0);

    // Mask gating of irq, unmapped reads, FALL_EN readback.
    bus_write(0, 3'd2, 32'h0);
    @(negedge clk);
    in0 = 4'h8;
    wait_edges(5);
    in0 = 4'h0;
    wait_edges(5);
    bus_read(0, 3'd3, r_val); check_value("cap_bit3", r_val, 32'h8);
    check_value("irq_masked", 32'(irq0), 32'h0);
    bus_write(0, 3'd2, 32'h8);
    check_value("irq_after_mask", 32'(irq0), 32'h1);
    bus_read(0, 3'd5, r_val); check_value("addr5", r_val, 32'h0);
    bus_read(0, 3'd6, r_val); check_value("addr6", r_val, 32'h0);
    bus_read(0, 3'd7, r_val); check_value("addr7", r_val, 32'h0);
    bus_read(0, 3'd4, r_val); check_value("fall_en_rb", r_val, 32'h8);

    // Debounce: a 7-cycle glitch is rejected.
    bus_write(1, 3'd1, 32'h1);
    @(negedge clk);
    in8 = 4'h1;
    wait_edges(7);
    in8 = 4'h0;
    wait_edges(15);
    bus_read(1, 3'd0, r_val); check_value("glitch_db", r_val, 32'h0);
    bus_read(1, 3'd3, r_val); check_value("glitch_cap", r_val, 32'h0);

    // Stable input: db at N+9, readdata at N+10.
    @(negedge clk);
    address = 3'd0;
    in8     = 4'h1;
    wait_edges(10);
    check_value("db8_early", rd8, 32'h0);
    wait_edges(1);
    check_value("db8_set", rd8, 32'h1);
    bus_read(1, 3'd3, r_val); check_value("cap8_rise", r_val, 32'h1);
    check_value("irq8_masked", 32'(irq8), 32'h0);

    // Reset in the middle of a debounce count.
    @(negedge clk);
    in8 = 4'h0;
    wait_edges(20);
    @(negedge clk);
    address = 3'd0;
    in8     = 4'h1;
    wait_edges(7);
    reset_n = 1'b0;
    #2;
    check_value("mid_rst_rd8", rd8, 32'h0);
    check_value("mid_rst_irq8", 32'(irq8), 32'h0);
    check_value("mid_rst_rd0", rd0, 32'h0);
    check_value("mid_rst_irq0", 32'(irq0), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    wait_edges(10);
    check_value("post_rst_early", rd8, 32'h0);
    wait_edges(1);
    check_value("post_rst_db", rd8, 32'h1);
    bus_read(1, 3'd3, r_val); check_value("post_rst_cap", r_val, 32'h0);
    bus_read(1, 3'd4, r_val); check_value("post_rst_fall_en", r_val, 32'hF);
    bus_read(1, 3'd1, r_val); check_value("post_rst_rise_en", r_val, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
